// File: rtl/player_shot_controller.sv
// Purpose : single player-shot state machine: launch on fire, climb on move_tick,
//           retire at the top (miss) or show a timed explosion on hit.
// Latency : 1 cycle from fire/move_tick/hit to registered outputs.
// Backpr. : none; enable=0 freezes everything and pulses seen meanwhile are dropped.
//
// Ports:
//   clk_36MHz   - system clock, all state on its rising edge
//   reset       - asynchronous active-low reset
//   enable      - game-running gate, 0 holds all state
//   fire        - one-cycle launch pulse (only honoured in IDLE)
//   move_tick   - one-cycle movement / explosion-timing strobe
//   player_x    - cannon left x, sampled once at launch
//   hit         - collision report for the in-flight shot
//   shot_active - shot sprite visible (in flight)
//   exploding   - explosion sprite visible
//   shot_x      - shot sprite x
//   shot_y      - shot sprite y
//   shot_count  - shots launched, saturating at 255

module player_shot_controller #(
   parameter int X_WIDTH       = 10,
   parameter int Y_WIDTH       = 10,
   parameter int X_OFFSET      = 7,
   parameter int START_Y       = 440,
   parameter int TOP_Y         = 16,
   parameter int STEP          = 4,
   parameter int EXPLODE_TICKS = 8
) (
   input  logic               clk_36MHz,
   input  logic               reset,
   input  logic               enable,
   input  logic               fire,
   input  logic               move_tick,
   input  logic [X_WIDTH-1:0] player_x,
   input  logic               hit,
   output logic               shot_active,
   output logic               exploding,
   output logic [X_WIDTH-1:0] shot_x,
   output logic [Y_WIDTH-1:0] shot_y,
   output logic [7:0]         shot_count
);

   // ------------------------------------------------------------------
   // Constants
   // ------------------------------------------------------------------
   localparam logic [1:0] ST_IDLE    = 2'd0;
   localparam logic [1:0] ST_FLYING  = 2'd1;
   localparam logic [1:0] ST_EXPLODE = 2'd2;

   localparam int CNT_W = $clog2(EXPLODE_TICKS + 1);
   localparam int YW1   = Y_WIDTH + 1;

   localparam logic [Y_WIDTH-1:0] START_Y_C  = Y_WIDTH'(START_Y);
   localparam logic [Y_WIDTH-1:0] STEP_C     = Y_WIDTH'(STEP);
   localparam logic [X_WIDTH-1:0] X_OFFSET_C = X_WIDTH'(X_OFFSET);
   localparam logic [CNT_W-1:0]   EXPL_LOAD  = CNT_W'(EXPLODE_TICKS);
   localparam logic [CNT_W-1:0]   EXPL_ONE   = CNT_W'(1);
   // One bit wider than y so TOP_Y+STEP cannot overflow the compare.
   localparam logic [YW1-1:0]     MISS_LIMIT = YW1'(TOP_Y + STEP);

   // ------------------------------------------------------------------
   // State
   // ------------------------------------------------------------------
   logic [1:0]         state_q,  state_d;
   logic               active_q, active_d;
   logic               expl_q,   expl_d;
   logic [X_WIDTH-1:0] x_q,      x_d;
   logic [Y_WIDTH-1:0] y_q,      y_d;
   logic [7:0]         count_q,  count_d;
   logic [CNT_W-1:0]   ecnt_q,   ecnt_d;

   // A further step would carry the shot above TOP_Y: that tick retires it.
   logic at_top;
   assign at_top = ({1'b0, y_q} < MISS_LIMIT);

   // ------------------------------------------------------------------
   // Next-state logic
   // ------------------------------------------------------------------
   always_comb begin
      state_d  = state_q;
      active_d = active_q;
      expl_d   = expl_q;
      x_d      = x_q;
      y_d      = y_q;
      count_d  = count_q;
      ecnt_d   = ecnt_q;

      if (enable) begin
         case (state_q)
            ST_IDLE: begin
               // hit and move_tick have no meaning without a shot
               if (fire) begin
                  state_d  = ST_FLYING;
                  active_d = 1'b1;
                  x_d      = player_x + X_OFFSET_C;
                  y_d      = START_Y_C;
                  if (count_q != 8'hFF) begin
                     count_d = count_q + 8'd1;
                  end
               end
            end

            ST_FLYING: begin
               // hit wins over a coincident move_tick so the explosion
               // appears exactly where the collision was detected
               if (hit) begin
                  state_d  = ST_EXPLODE;
                  active_d = 1'b0;
                  expl_d   = 1'b1;
                  ecnt_d   = EXPL_LOAD;
               end else if (move_tick) begin
                  if (at_top) begin
                     state_d  = ST_IDLE;
                     active_d = 1'b0;
                     y_d      = START_Y_C;
                  end else begin
                     y_d = y_q - STEP_C;
                  end
               end
            end

            ST_EXPLODE: begin
               if (move_tick) begin
                  if (ecnt_q == EXPL_ONE) begin
                     state_d = ST_IDLE;
                     expl_d  = 1'b0;
                     y_d     = START_Y_C;
                     ecnt_d  = '0;
                  end else begin
                     ecnt_d = ecnt_q - EXPL_ONE;
                  end
               end
            end

            default: begin
               // unreachable encoding: recover to a clean idle
               state_d  = ST_IDLE;
               active_d = 1'b0;
               expl_d   = 1'b0;
               y_d      = START_Y_C;
               ecnt_d   = '0;
            end
         endcase
      end
   end

   // ------------------------------------------------------------------
   // Registers
   // ------------------------------------------------------------------
   always_ff @(posedge clk_36MHz or negedge reset) begin
      if (!reset) begin
         state_q  <= ST_IDLE;
         active_q <= 1'b0;
         expl_q   <= 1'b0;
         x_q      <= '0;
         y_q      <= START_Y_C;
         count_q  <= 8'd0;
         ecnt_q   <= '0;
      end else begin
         state_q  <= state_d;
         active_q <= active_d;
         expl_q   <= expl_d;
         x_q      <= x_d;
         y_q      <= y_d;
         count_q  <= count_d;
         ecnt_q   <= ecnt_d;
      end
   end

   // ------------------------------------------------------------------
   // Outputs (all straight from flops)
   // ------------------------------------------------------------------
   assign shot_active = active_q;
   assign exploding   = expl_q;
   assign shot_x      = x_q;
   assign shot_y      = y_q;
   assign shot_count  = count_q;

endmodule

// File: tb/tb_player_shot_controller.sv
// Purpose : self-checking bench for player_shot_controller (default parameters).
// Latency : expected outputs queued per driven cycle, popped one cycle later.
// Backpr. : n/a.

module tb_player_shot_controller;

   logic       clk_36MHz = 1'b0;
   logic       reset     = 1'b1;
   logic       enable    = 1'b1;
   logic       fire      = 1'b0;
   logic       move_tick = 1'b0;
   logic [9:0] player_x  = 10'd0;
   logic       hit       = 1'b0;
   logic       shot_active;
   logic       exploding;
   logic [9:0] shot_x;
   logic [9:0] shot_y;
   logic [7:0] shot_count;

   player_shot_controller dut (
      .clk_36MHz  (clk_36MHz),
      .reset      (reset),
      .enable     (enable),
      .fire       (fire),
      .move_tick  (move_tick),
      .player_x   (player_x),
      .hit        (hit),
      .shot_active(shot_active),
      .exploding  (exploding),
      .shot_x     (shot_x),
      .shot_y     (shot_y),
      .shot_count (shot_count)
   );

   always #5 clk_36MHz = ~clk_36MHz;

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
      end
   endtask

   // ------------------------------------------------------------------
   // Reference model of the shot behaviour
   // ------------------------------------------------------------------
   typedef enum int {M_IDLE, M_FLY, M_EXP} mstate_t;
   mstate_t m_state;
   int      m_act, m_expl, m_x, m_y, m_cnt, m_ec;

   typedef struct {
      int act;
      int expl;
      int x;
      int y;
      int cnt;
   } exp_t;
   exp_t sb_q[$];

   task automatic model_reset();
      m_state = M_IDLE; m_act = 0; m_expl = 0; m_x = 0; m_y = 440; m_cnt = 0; m_ec = 0;
   endtask

   task automatic model_update(input bit f, input bit t, input bit h, input bit en, input int px);
      if (!en) return;
      case (m_state)
         M_IDLE: if (f) begin
            m_state = M_FLY; m_act = 1; m_x = (px + 7) % 1024; m_y = 440;
            if (m_cnt < 255) m_cnt = m_cnt + 1;
         end
         M_FLY: if (h) begin
            m_state = M_EXP; m_act = 0; m_expl = 1; m_ec = 8;
         end else if (t) begin
            if (m_y >= 16 + 4) m_y = m_y - 4;
            else begin m_state = M_IDLE; m_act = 0; m_y = 440; end
         end
         M_EXP: if (t) begin
            m_ec = m_ec - 1;
            if (m_ec == 0) begin m_state = M_IDLE; m_expl = 0; m_y = 440; end
         end
         default: ;
      endcase
   endtask

   task automatic compare_head();
      exp_t e;
      if (sb_q.size() == 0) begin
         check("sb_empty", 32'd1, 32'd0);
         return;
      end
      e = sb_q.pop_front();
      check("shot_active", {31'd0, shot_active}, e.act);
      check("exploding",   {31'd0, exploding},   e.expl);
      check("shot_x",      {22'd0, shot_x},      e.x);
      check("shot_y",      {22'd0, shot_y},      e.y);
      check("shot_count",  {24'd0, shot_count},  e.cnt);
      check("exclusive",   {31'd0, shot_active & exploding}, 32'd0);
   endtask

   // One clock: drive inputs, predict, push; sample after the edge, pop, compare.
   task automatic step(input bit f, input bit t, input bit h, input bit en);
      @(negedge clk_36MHz);
      fire = f; move_tick = t; hit = h; enable = en;
      model_update(f, t, h, en, int'(player_x));
      sb_q.push_back('{m_act, m_expl, m_x, m_y, m_cnt});
      @(posedge clk_36MHz);
      #1;
      compare_head();
   endtask

   task automatic do_reset();
      @(negedge clk_36MHz);
      fire = 0; move_tick = 0; hit = 0; enable = 1;
      reset = 1'b0;
      model_reset();
      #1;
      check("rst_active", {31'd0, shot_active}, 32'd0);
      check("rst_expl",   {31'd0, exploding},   32'd0);
      check("rst_x",      {22'd0, shot_x},      32'd0);
      check("rst_y",      {22'd0, shot_y},      32'd440);
      check("rst_count",  {24'd0, shot_count},  32'd0);
      @(negedge clk_36MHz);
      reset = 1'b1;
   endtask

   initial begin
      model_reset();
      #3;
      do_reset();
      step(0, 0, 0, 1);

      // Reset mid-flight aborts immediately
      player_x = 10'd50;
      step(1, 0, 0, 1);
      for (int i = 0; i < 3; i++) step(0, 1, 0, 1);
      check("pre_rst_y", {22'd0, shot_y}, 32'd428);
      do_reset();

      // Launch, then a fire during flight is ignored
      player_x = 10'd100;
      step(1, 0, 0, 1);
      check("launch_x", {22'd0, shot_x}, 32'd107);
      check("launch_cnt", {24'd0, shot_count}, 32'd1);
      player_x = 10'd200;  // moving cannon must not move the shot
      step(1, 0, 0, 1);
      step(0, 0, 0, 1);
      check("fly_fire_cnt", {24'd0, shot_count}, 32'd1);

      // Climb to the top, then miss
      for (int i = 0; i < 106; i++) step(0, 1, 0, 1);
      check("top_y", {22'd0, shot_y}, 32'd16);
      check("top_active", {31'd0, shot_active}, 32'd1);
      step(0, 1, 0, 1);
      check("miss_active", {31'd0, shot_active}, 32'd0);
      check("miss_expl", {31'd0, exploding}, 32'd0);
      check("miss_y", {22'd0, shot_y}, 32'd440);
      step(0, 1, 1, 1);  // hit/move_tick in IDLE do nothing

      // Hit together with move_tick at y=300
      step(1, 0, 0, 1);
      for (int i = 0; i < 35; i++) step(0, 1, 0, 1);
      check("hit_pre_y", {22'd0, shot_y}, 32'd300);
      step(0, 1, 1, 1);
      check("hit_expl", {31'd0, exploding}, 32'd1);
      check("hit_y", {22'd0, shot_y}, 32'd300);
      for (int i = 0; i < 7; i++) begin
         step(1, 0, 1, 1);  // fire/hit ignored while exploding
         step(0, 1, 0, 1);
      end
      check("expl_7", {31'd0, exploding}, 32'd1);
      step(1, 1, 0, 1);  // 8th tick: back to IDLE, coincident fire dropped
      check("expl_done", {31'd0, exploding}, 32'd0);
      step(0, 0, 0, 1);
      check("drop_fire", {31'd0, shot_active}, 32'd0);
      step(1, 0, 0, 1);
      check("relaunch", {31'd0, shot_active}, 32'd1);

      // Enable gating during flight
      for (int i = 0; i < 10; i++) step(0, 1, 0, 1);
      for (int i = 0; i < 5; i++) step(0, 1, 0, 0);
      step(0, 0, 1, 0);
      check("gate_y", {22'd0, shot_y}, 32'd400);
      check("gate_expl", {31'd0, exploding}, 32'd0);
      step(0, 1, 0, 1);
      check("resume_y", {22'd0, shot_y}, 32'd396);
      step(0, 0, 1, 1);
      for (int i = 0; i < 8; i++) step(0, 1, 0, 1);

      // Saturating shot counter
      do_reset();
      player_x = 10'd10;
      for (int n = 0; n < 256; n++) begin
         step(1, 0, 0, 1);
         for (int i = 0; i < 107; i++) step(0, 1, 0, 1);
         if (n == 254) check("cnt_255", {24'd0, shot_count}, 32'd255);
      end
      check("cnt_sat", {24'd0, shot_count}, 32'd255);

      // x wraps modulo 2^10
      player_x = 10'd1020;
      step(1, 0, 0, 1);
      check("x_wrap", {22'd0, shot_x}, 32'd3);
      step(0, 0, 0, 1);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
